// File: rtl/mem_stage.sv
// MEM pipeline stage: registers the EX->MEM bus, extracts/extends SRAM load data
// and drives the MEM->WB and MEM->ID forwarding buses.
module mem_stage #(
   parameter int EX_TO_MEM_WD = 79,
   parameter int MEM_TO_WB_WD = 70,
   parameter int MEM_TO_ID_WD = 38,
   parameter int STALL_W      = 6
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic [STALL_W-1:0]      stall,
   input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
   input  logic [31:0]             data_sram_rdata,
   output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
   output logic [MEM_TO_ID_WD-1:0] mem_to_id_bus
);

   localparam logic [2:0] OP_LW  = 3'b000;
   localparam logic [2:0] OP_LB  = 3'b001;
   localparam logic [2:0] OP_LBU = 3'b010;
   localparam logic [2:0] OP_LH  = 3'b011;
   localparam logic [2:0] OP_LHU = 3'b100;

   logic [EX_TO_MEM_WD-1:0] bus_r;
   logic                    hold_valid;
   logic [31:0]             hold_data;

   logic        stall_mem;
   logic        stall_wb;
   logic        bus_load;
   logic        bus_bubble;
   logic        bus_freeze;

   logic [2:0]  mem_op;
   logic [31:0] pc;
   logic        ram_en;
   logic [3:0]  ram_wen;
   logic        sel_rf_res;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] ex_result;
   logic [1:0]  off;

   logic [31:0] rdata_eff;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_val;
   logic [31:0] rf_wdata;

   // stall[3] freezes MEM's input register, stall[4] freezes WB behind it
   assign stall_mem  = stall[3];
   assign stall_wb   = stall[4];
   assign bus_load   = ~stall_mem;
   assign bus_bubble = stall_mem & ~stall_wb;
   assign bus_freeze = stall_mem & stall_wb;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         bus_r <= '0;
      end else if (bus_bubble) begin
         bus_r <= '0;
      end else if (bus_load) begin
         bus_r <= ex_to_mem_bus;
      end
   end

   assign mem_op     = bus_r[78:76];
   assign pc         = bus_r[75:44];
   assign ram_en     = bus_r[43];
   assign ram_wen    = bus_r[42:39];
   assign sel_rf_res = bus_r[38];
   assign rf_we      = bus_r[37];
   assign rf_waddr   = bus_r[36:32];
   assign ex_result  = bus_r[31:0];
   assign off        = ex_result[1:0];

   // SRAM data is only valid for one cycle; latch it on the first frozen cycle
   // so a long stall keeps the original load value without re-reading.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hold_valid <= 1'b0;
         hold_data  <= '0;
      end else if (bus_load || bus_bubble) begin
         hold_valid <= 1'b0;
      end else if (bus_freeze && !hold_valid && ram_en) begin
         hold_valid <= 1'b1;
         hold_data  <= data_sram_rdata;
      end
   end

   assign rdata_eff = hold_valid ? hold_data : data_sram_rdata;

   always_comb begin
      byte_sel = rdata_eff[7:0];
      case (off)
         2'd0: byte_sel = rdata_eff[7:0];
         2'd1: byte_sel = rdata_eff[15:8];
         2'd2: byte_sel = rdata_eff[23:16];
         2'd3: byte_sel = rdata_eff[31:24];
         default: byte_sel = rdata_eff[7:0];
      endcase
   end

   assign half_sel = off[1] ? rdata_eff[31:16] : rdata_eff[15:0];

   always_comb begin
      load_val = rdata_eff;
      case (mem_op)
         OP_LW:   load_val = rdata_eff;
         OP_LB:   load_val = {{24{byte_sel[7]}}, byte_sel};
         OP_LBU:  load_val = {24'h0, byte_sel};
         OP_LH:   load_val = {{16{half_sel[15]}}, half_sel};
         OP_LHU:  load_val = {16'h0, half_sel};
         default: load_val = rdata_eff;
      endcase
   end

   assign rf_wdata = (sel_rf_res && ram_en) ? load_val : ex_result;

   assign mem_to_wb_bus = {pc, rf_we, rf_waddr, rf_wdata};
   assign mem_to_id_bus = mem_to_wb_bus[37:0];

   // Stores carry rf_we=0 from EX, so the write mask needs no further gating.
   logic unused_bits;
   assign unused_bits = ^{ram_wen, stall[STALL_W-1:5], stall[2:0]};

endmodule
